// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UDP TX header+payload stream among N_PORTS sources.
// A per-frame watchdog closes a stalled frame with an error beat, then drains the source to its tlast.
module udp_tx_arbiter #(
  parameter int          N_PORTS = 2,
  parameter int          DATA_W  = 8,
  parameter int          HDR_W   = 64,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          s_hdr_valid,
  output logic [N_PORTS-1:0]          s_hdr_ready,
  input  logic [N_PORTS*HDR_W-1:0]    s_hdr_data,
  input  logic [N_PORTS*DATA_W-1:0]   s_payload_tdata,
  input  logic [N_PORTS-1:0]          s_payload_tvalid,
  output logic [N_PORTS-1:0]          s_payload_tready,
  input  logic [N_PORTS-1:0]          s_payload_tlast,
  input  logic [N_PORTS-1:0]          s_payload_tuser,
  output logic                        m_hdr_valid,
  input  logic                        m_hdr_ready,
  output logic [HDR_W-1:0]            m_hdr_data,
  output logic [DATA_W-1:0]           m_payload_tdata,
  output logic                        m_payload_tvalid,
  input  logic                        m_payload_tready,
  output logic                        m_payload_tlast,
  output logic                        m_payload_tuser,
  output logic [1:0]                  grant,
  output logic                        busy,
  output logic                        abort
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_TERM, S_DRAIN} state_t;

  state_t              r_state, w_next;
  logic [1:0]          r_grant, r_last_grant, w_pick;
  logic [15:0]         r_cnt;
  logic                w_any;
  logic [N_PORTS-1:0]  w_gnt_oh;
  logic                w_sel_hvalid, w_sel_pvalid, w_sel_plast, w_sel_puser;
  logic [HDR_W-1:0]    w_sel_hdata;
  logic [DATA_W-1:0]   w_sel_pdata;
  logic                w_pay_hs, w_expire;

  // Granted-port mux, built from a one-hot so no index ever exceeds N_PORTS
  always_comb begin
    w_gnt_oh     = '0;
    w_sel_hvalid = 1'b0;
    w_sel_hdata  = '0;
    w_sel_pvalid = 1'b0;
    w_sel_pdata  = '0;
    w_sel_plast  = 1'b0;
    w_sel_puser  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_grant == 2'(i)) begin
        w_gnt_oh[i]  = 1'b1;
        w_sel_hvalid = s_hdr_valid[i];
        w_sel_hdata  = s_hdr_data[i*HDR_W +: HDR_W];
        w_sel_pvalid = s_payload_tvalid[i];
        w_sel_pdata  = s_payload_tdata[i*DATA_W +: DATA_W];
        w_sel_plast  = s_payload_tlast[i];
        w_sel_puser  = s_payload_tuser[i];
      end
    end
  end

  // Round-robin search starting just after the previous frame's owner
  always_comb begin
    w_pick = r_last_grant;
    w_any  = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      for (int j = 0; j < N_PORTS; j++) begin
        if (!w_any && j == (int'(r_last_grant) + k) % N_PORTS && s_hdr_valid[j]) begin
          w_any  = 1'b1;
          w_pick = 2'(j);
        end
      end
    end
  end

  assign w_pay_hs = w_sel_pvalid && m_payload_tready;
  // A handshake in the expiry cycle wins: the frame is still alive
  assign w_expire = (TIMEOUT != 16'd0) && (r_cnt == TIMEOUT - 16'd1) && !w_pay_hs;

  always_comb begin
    w_next           = r_state;
    s_hdr_ready      = '0;
    s_payload_tready = '0;
    m_hdr_valid      = 1'b0;
    m_hdr_data       = '0;
    m_payload_tdata  = '0;
    m_payload_tvalid = 1'b0;
    m_payload_tlast  = 1'b0;
    m_payload_tuser  = 1'b0;
    abort            = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_HDR;
      S_HDR: begin
        m_hdr_valid = w_sel_hvalid;
        m_hdr_data  = w_sel_hdata;
        s_hdr_ready = w_gnt_oh & {N_PORTS{m_hdr_ready}};
        if (w_sel_hvalid && m_hdr_ready) w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        m_payload_tdata  = w_sel_pdata;
        m_payload_tvalid = w_sel_pvalid;
        m_payload_tlast  = w_sel_plast;
        m_payload_tuser  = w_sel_puser;
        s_payload_tready = w_gnt_oh & {N_PORTS{m_payload_tready}};
        if (w_pay_hs && w_sel_plast) w_next = S_IDLE;
        else if (w_expire) begin
          abort  = 1'b1;
          w_next = S_TERM;
        end
      end
      S_TERM: begin
        m_payload_tvalid = 1'b1;
        m_payload_tlast  = 1'b1;
        m_payload_tuser  = 1'b1;
        if (m_payload_tready) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        s_payload_tready = w_gnt_oh;
        if (w_sel_pvalid && w_sel_plast) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= 2'(N_PORTS - 1);
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) r_grant <= w_pick;
      if (r_state != S_IDLE && w_next == S_IDLE) r_last_grant <= r_grant;
      // Held at zero outside PAYLOAD, so every frame starts with a fresh count
      if (r_state != S_PAYLOAD || w_pay_hs) r_cnt <= '0;
      else if (r_cnt != 16'hFFFF)           r_cnt <= r_cnt + 16'd1;
    end
  end

  assign grant = r_grant;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: queued per-port source model drives frames, scoreboard checks the
// header/payload streams in predicted round-robin order, plus watchdog and reset scenarios.
module tb_udp_tx_arbiter;
  localparam int          NP = 2;
  localparam int          DW = 8;
  localparam int          HW = 64;
  localparam logic [15:0] TO = 16'd8;
  localparam int K_HDR = 0, K_BEAT = 1, K_GAP = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     s_hdr_valid, s_hdr_ready;
  logic [NP*HW-1:0]  s_hdr_data;
  logic [NP*DW-1:0]  s_payload_tdata;
  logic [NP-1:0]     s_payload_tvalid, s_payload_tready, s_payload_tlast, s_payload_tuser;
  logic              m_hdr_valid, m_hdr_ready;
  logic [HW-1:0]     m_hdr_data;
  logic [DW-1:0]     m_payload_tdata;
  logic              m_payload_tvalid, m_payload_tready, m_payload_tlast, m_payload_tuser;
  logic [1:0]        grant;
  logic              busy, abort;

  udp_tx_arbiter #(.N_PORTS(NP), .DATA_W(DW), .HDR_W(HW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr_data(s_hdr_data),
    .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid),
    .s_payload_tready(s_payload_tready), .s_payload_tlast(s_payload_tlast),
    .s_payload_tuser(s_payload_tuser),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr_data(m_hdr_data),
    .m_payload_tdata(m_payload_tdata), .m_payload_tvalid(m_payload_tvalid),
    .m_payload_tready(m_payload_tready), .m_payload_tlast(m_payload_tlast),
    .m_payload_tuser(m_payload_tuser),
    .grant(grant), .busy(busy), .abort(abort)
  );

  always #5 clock = ~clock;

  typedef struct { int kind; logic [HW-1:0] hdr; logic [DW-1:0] d; logic last; } item_t;
  typedef struct { int port; logic [HW-1:0] hdr; } ehdr_t;

  item_t       srcq[NP][$];
  ehdr_t       exp_hdr[$];
  logic [9:0]  exp_pay[$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, n_abort = 0, abort_gap = -1, last_pay_cyc = 0, hdr_hs_cyc = 0, n_pay = 0;
  bit tog = 1'b0, chk_busy_next = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input int p, input logic [15:0] dport, input int n, input logic [7:0] base);
    item_t it;
    it.kind = K_HDR; it.hdr = {32'h0A00_0001, 16'(4000 + p), dport}; it.d = '0; it.last = 1'b0;
    srcq[p].push_back(it);
    exp_hdr.push_back('{p, it.hdr});
    for (int i = 0; i < n; i++) begin
      it.kind = K_BEAT; it.d = base + 8'(i); it.last = (i == n - 1);
      srcq[p].push_back(it);
      exp_pay.push_back({it.d, it.last, 1'b0});
    end
  endtask

  // Source-side items that the DUT will consume without forwarding them
  task automatic push_src(input int p, input int kind, input logic [7:0] d, input logic last);
    item_t it;
    it.kind = kind; it.hdr = '0; it.d = d; it.last = last;
    srcq[p].push_back(it);
  endtask

  task automatic drive();
    item_t h;
    s_hdr_valid = '0; s_payload_tvalid = '0; s_payload_tlast = '0; s_payload_tuser = '0;
    for (int p = 0; p < NP; p++) begin
      if (srcq[p].size() > 0) begin
        h = srcq[p][0];
        if (h.kind == K_HDR) begin
          s_hdr_valid[p] = 1'b1;
          s_hdr_data[p*HW +: HW] = h.hdr;
        end else if (h.kind == K_BEAT) begin
          s_payload_tvalid[p] = 1'b1;
          s_payload_tdata[p*DW +: DW] = h.d;
          s_payload_tlast[p] = h.last;
        end
      end
    end
    m_hdr_ready = 1'b1;
    m_payload_tready = tog ? (cyc % 2 == 0) : 1'b1;
  endtask

  task automatic observe();
    ehdr_t e;
    logic [9:0] ep;
    if (chk_busy_next) begin
      chk("idle_after_tlast", busy, 0);
      chk_busy_next = 1'b0;
    end
    if (abort) begin
      n_abort++;
      abort_gap = cyc - last_pay_cyc;
    end
    if (m_hdr_valid && m_hdr_ready) begin
      hdr_hs_cyc = cyc;
      if (exp_hdr.size() == 0) chk("hdr_unexpected", 1'b1, 1'b0 ^ busy ^ busy);
      else begin
        e = exp_hdr.pop_front();
        chk("hdr_data", m_hdr_data, e.hdr);
        chk("hdr_grant", grant, 64'(e.port));
      end
    end
    if (m_payload_tvalid && m_payload_tready) begin
      last_pay_cyc = cyc;
      n_pay++;
      if (exp_pay.size() == 0) chk("pay_unexpected", {m_payload_tdata, m_payload_tlast, m_payload_tuser}, 10'h3FF);
      else begin
        ep = exp_pay.pop_front();
        chk("pay_beat", {m_payload_tdata, m_payload_tlast, m_payload_tuser}, ep);
      end
      if (m_payload_tlast && !m_payload_tuser) chk_busy_next = 1'b1;
    end
    for (int p = 0; p < NP; p++) begin
      if (!busy || grant != 2'(p)) begin
        chk("loser_hdr_ready", s_hdr_ready[p], 0);
        chk("loser_pay_ready", s_payload_tready[p], 0);
      end
    end
  endtask

  task automatic run(input int budget, input int stop_beats);
    int n = 0;
    bit acc[NP];
    item_t h;
    int beats0 = n_pay;
    while ((srcq[0].size() > 0 || srcq[1].size() > 0 || exp_hdr.size() > 0 || exp_pay.size() > 0)
           && n < budget) begin
      drive();
      @(negedge clock);
      observe();
      for (int p = 0; p < NP; p++) begin
        acc[p] = 1'b0;
        if (srcq[p].size() > 0) begin
          h = srcq[p][0];
          if (h.kind == K_HDR)       acc[p] = s_hdr_valid[p] && s_hdr_ready[p];
          else if (h.kind == K_BEAT) acc[p] = s_payload_tvalid[p] && s_payload_tready[p];
          else                       acc[p] = 1'b1;
        end
      end
      if (stop_beats > 0 && n_pay - beats0 >= stop_beats) return;
      @(posedge clock); #1;
      for (int p = 0; p < NP; p++) if (acc[p]) void'(srcq[p].pop_front());
      cyc++;
      n++;
    end
    chk("run_within_budget", n < budget, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < NP; p++) srcq[p].delete();
      drive();
      @(negedge clock);
      observe();
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_abort"}, abort, 0);
    chk({tag, "_m_valids"}, {m_hdr_valid, m_payload_tvalid}, 0);
    chk({tag, "_s_readys"}, {s_hdr_ready, s_payload_tready}, 0);
    chk({tag, "_m_data"}, {m_hdr_data, m_payload_tdata, m_payload_tlast, m_payload_tuser}, 0);
  endtask

  initial begin
    int start;
    reset = 1'b1;
    s_hdr_data = '0; s_payload_tdata = '0;
    drive();
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: single frame, one arbitration cycle before the header handshake
    push_frame(0, 16'd1234, 4, 8'h01);
    start = cyc;
    run(100, 0);
    chk("hdr_latency", 64'(hdr_hs_cyc - start), 1);
    idle(2);

    // 2: both ports contend; port0 owned the last frame, so port1 leads the alternation
    for (int f = 0; f < 3; f++) begin
      push_frame(1, 16'(200 + f), 3, 8'h80 + 8'(16 * f));
      push_frame(0, 16'(100 + f), 3, 8'h20 + 8'(16 * f));
    end
    run(300, 0);
    idle(2);

    // 3: downstream ready toggles every cycle; watchdog must stay quiet
    tog = 1'b1;
    push_frame(0, 16'd555, 16, 8'h40);
    run(200, 0);
    tog = 1'b0;
    idle(2);
    chk("no_abort_toggle", n_abort, 0);

    // 4: port1 stalls after two beats -> abort, error beat, drain, then port0
    push_frame(1, 16'd777, 0, 8'h00);
    exp_hdr.delete();
    srcq[1].delete();
    push_src(1, K_HDR, 8'h00, 1'b0);
    srcq[1][0].hdr = {32'h0A00_0001, 16'd4001, 16'd777};
    exp_hdr.push_back('{1, {32'h0A00_0001, 16'd4001, 16'd777}});
    push_src(1, K_BEAT, 8'h11, 1'b0); exp_pay.push_back({8'h11, 1'b0, 1'b0});
    push_src(1, K_BEAT, 8'h12, 1'b0); exp_pay.push_back({8'h12, 1'b0, 1'b0});
    exp_pay.push_back({8'h00, 1'b1, 1'b1});
    for (int i = 0; i < 15; i++) push_src(1, K_GAP, 8'h00, 1'b0);
    push_src(1, K_BEAT, 8'hAA, 1'b0);
    push_src(1, K_BEAT, 8'hBB, 1'b1);
    for (int i = 0; i < 3; i++) push_src(0, K_GAP, 8'h00, 1'b0);
    push_frame(0, 16'd888, 2, 8'h51);
    run(200, 0);
    idle(2);
    chk("abort_count", n_abort, 1);
    chk("abort_gap", 64'(abort_gap), 8);

    // 6: tlast handshake lands exactly on the expiry count
    push_frame(0, 16'd999, 0, 8'h00);
    push_src(0, K_BEAT, 8'h61, 1'b0); exp_pay.push_back({8'h61, 1'b0, 1'b0});
    for (int i = 0; i < 7; i++) push_src(0, K_GAP, 8'h00, 1'b0);
    push_src(0, K_BEAT, 8'h62, 1'b1); exp_pay.push_back({8'h62, 1'b1, 1'b0});
    run(100, 0);
    idle(2);
    chk("no_abort_boundary", n_abort, 1);

    // 5: reset while byte 3 is on the bus; last winner was port0, reset hands priority back to it
    push_frame(0, 16'd321, 6, 8'h31);
    run(100, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    cyc++;
    @(negedge clock);
    chk_reset_outputs("midframe_reset");
    @(posedge clock); #1;
    cyc++;
    reset = 1'b0;
    for (int p = 0; p < NP; p++) srcq[p].delete();
    exp_hdr.delete();
    exp_pay.delete();
    chk_busy_next = 1'b0;
    push_frame(0, 16'd1, 2, 8'hC0);
    push_frame(1, 16'd2, 2, 8'hD0);
    run(100, 0);
    idle(2);
    chk("final_abort_count", n_abort, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
